mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store access unit between the pipeline MEM stage and the byte-addressed data memory. It converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses. Loads get lane extraction and sign or zero extension. Sub-word stores are done as a two-cycle read-modify-write, and misaligned or illegal requests are rejected with an error response.

## Interface
- ADDRESS_WIDTH, 32, byte address width of request and memory side.
- DATA_WIDTH, 32, data word width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 byte, 001 half, 010 word, 100 byte unsigned (load only), 101 half unsigned (load only).
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- mem_addr  out  ADDRESS_WIDTH  word-aligned address: low 2 bits always 0.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  DATA_WIDTH  full word to write.
- mem_rdata  in  DATA_WIDTH  combinational read of the word at mem_addr.

## Operation
- Lane mapping: byte base+k is mem_rdata/mem_wdata[8k+7:8k]. This holds for both read and write words.
- FSM states:
  - IDLE: req_ready = 1.
  - WRITE: req_ready = 0. Requesters hold their request until it is accepted.
- Alignment is checked on acceptance in IDLE:
  - Half requests are misaligned when addr[0] = 1.
  - Word requests are misaligned when addr[1:0] != 0.
  - funct3 011/110/111 are illegal. funct3 100/101 with req_we = 1 are illegal.
- Errored request: no memory write. Next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0. Stay in IDLE.
- Load, in IDLE:
  - mem_addr = {req_addr[31:2], 2'b00}.
  - Byte lane = addr[1:0]. Half lane = addr[1].
  - Extend per funct3 and register into resp_rdata. resp_valid next cycle.
- SW: mem_wr_en = 1 in the accept cycle with mem_wdata = req_wdata. resp_valid next cycle.
- SB/SH, accept cycle:
  - Read the aligned word.
  - Register the aligned address, plus a merged word in which the addressed lanes are replaced by req_wdata[7:0] or [15:0].
  - Go to WRITE.
- WRITE:
  - mem_addr = saved address, mem_wr_en = 1, mem_wdata = merged word.
  - Return to IDLE. resp_valid next cycle.
- When idle with no valid request: mem_wr_en = 0 and mem_addr follows req_addr aligned.

## Timing
- Reset (rst_n = 0 at an edge):
  - State becomes IDLE.
  - resp_valid, resp_err and resp_rdata all become 0.
  - Saved address and merged word become 0.
- While rst_n = 0, req_ready and mem_wr_en are forced to 0 combinationally.
  - Consequence: reset during WRITE aborts the merge, and no partial write occurs.
- Latency from accept edge to the resp_valid edge:
  - Loads, SW and errors: 1 cycle.
  - SB/SH: 2 cycles.
- Each accepted request produces exactly one resp_valid pulse. resp_rdata and resp_err hold their values until the next response.
- Back-to-back: a new request may be accepted in the same cycle that resp_valid is high for the previous one.
  - Sustained throughput: 1 request per cycle for loads and SW; 1 per 2 cycles for SB/SH.
- A load accepted in the cycle after a WRITE sees the newly written word. The memory write lands at the WRITE edge.
- req_valid during WRITE is ignored and produces no side effects.

## Test plan
- Preload word 0x100 = 0x876543F1. Then:
  - LB 0x100 -> resp_rdata 0xFFFFFFF1.
  - LBU 0x100 -> 0x000000F1.
  - LH 0x102 -> 0xFFFF8765.
  - LHU 0x102 -> 0x00008765.
  - Each response arrives 1 cycle after acceptance.
- SB 0x101 with wdata 0x123456AA on preloaded 0x876543F1:
  - req_ready low for exactly 1 cycle.
  - A single mem_wr_en pulse at mem_addr 0x100 with mem_wdata 0x8765AAF1.
  - resp_valid 2 cycles after accept.
  - A following LW 0x100 returns 0x8765AAF1.
- SW 0x104 = 0xDEADBEEF, immediately followed by LW 0x104 -> mem_wr_en in cycle 0, LW accepted in cycle 1, resp_rdata 0xDEADBEEF.
- Error cases, each giving resp_err = 1, resp_rdata 0 and no mem_wr_en:
  - LW 0x102.
  - SH 0x103.
  - Store with funct3 100.
- Reset asserted during the WRITE cycle of SH 0x200 -> no mem_wr_en; memory unchanged; all outputs 0 after the edge; IDLE afterwards.
- Random mix of 1000 requests against a reference memory model -> every response matches, and exactly one resp_valid per accepted request.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The master modport is the pipeline + memory side, the slave modport is the unit.
interface mem_access_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_wr_en;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: word-wide memory accesses, load lane extraction/extension,
// two-cycle read-modify-write for SB/SH, error response for misaligned/illegal requests.
//
// state   | meaning
// S_IDLE  | ready; accepts loads, SW, errors (1 cycle) or starts an SB/SH merge
// S_WRITE | writes the merged word at the saved address; request port stalled
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t                   r_state;
  logic                     r_resp_valid;
  logic                     r_resp_err;
  logic [DATA_WIDTH-1:0]    r_resp_rdata;
  logic [ADDRESS_WIDTH-1:0] r_save_addr;
  logic [DATA_WIDTH-1:0]    r_merge_word;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_illegal;
  logic                     w_misalign;
  logic                     w_err;
  logic                     w_is_sw;
  logic [ADDRESS_WIDTH-1:0] w_word_addr;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [DATA_WIDTH-1:0]    w_merged;

  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = rst_n && w_idle && bus.req_valid;
  assign w_word_addr = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign w_err       = w_illegal || w_misalign;
  assign w_is_sw     = bus.req_we && (bus.req_funct3 == F3_W);

  always_comb begin
    w_illegal = 1'b1;
    case (bus.req_funct3)
      F3_B, F3_H, F3_W: w_illegal = 1'b0;
      F3_BU, F3_HU:     w_illegal = bus.req_we;
      default:          w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   w_misalign = bus.req_addr[0];
      2'b10:   w_misalign = (bus.req_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (bus.req_addr[1:0])
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
  end

  assign w_half = bus.req_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    w_load_data = '0;
    case (bus.req_funct3)
      F3_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    w_load_data = bus.mem_rdata;
      F3_BU:   w_load_data = {24'h0, w_byte};
      F3_HU:   w_load_data = {16'h0, w_half};
      default: w_load_data = '0;
    endcase
  end

  // Only consulted for a legal SB/SH, so funct3[0] alone tells byte from half.
  always_comb begin
    w_merged = bus.mem_rdata;
    if (!bus.req_funct3[0]) begin
      case (bus.req_addr[1:0])
        2'd0:    w_merged[7:0]   = bus.req_wdata[7:0];
        2'd1:    w_merged[15:8]  = bus.req_wdata[7:0];
        2'd2:    w_merged[23:16] = bus.req_wdata[7:0];
        default: w_merged[31:24] = bus.req_wdata[7:0];
      endcase
    end else if (bus.req_addr[1]) begin
      w_merged[31:16] = bus.req_wdata[15:0];
    end else begin
      w_merged[15:0] = bus.req_wdata[15:0];
    end
  end

  assign bus.req_ready  = rst_n && w_idle;
  assign bus.mem_addr   = w_idle ? w_word_addr : r_save_addr;
  assign bus.mem_wdata  = w_idle ? bus.req_wdata : r_merge_word;
  assign bus.mem_wr_en  = rst_n && (!w_idle || (w_accept && !w_err && w_is_sw));
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_save_addr  <= '0;
      r_merge_word <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!bus.req_we) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load_data;
            end else if (w_is_sw) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= '0;
            end else begin
              r_save_addr  <= w_word_addr;
              r_merge_word <= w_merged;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus a random mix checked against
// a word-array reference model with arithmetic lane extraction and merging.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_idx  = 8'h0;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] <= pre_data;
    else if (bus.mem_wr_en === 1'b1) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];
  int    accepts  = 0;
  int    resp_cnt = 0;
  resp_t e_mon;
  wr_t   w_mon;

  always @(posedge clk) begin
    #1;
    if (bus.resp_valid === 1'b1) begin
      resp_cnt++;
      chk("resp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk("resp_cycle", cyc, e_mon.cyc);
        chk("resp_err", 32'(bus.resp_err), 32'(e_mon.err));
        chk("resp_rdata", bus.resp_rdata, e_mon.rdata);
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n && bus.mem_wr_en === 1'b1) begin
      chk("write_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w_mon = wr_q.pop_front();
        chk("write_addr", bus.mem_addr, w_mon.addr);
        chk("write_data", bus.mem_wdata, w_mon.data);
      end
    end
  end

  // Reference: requests take effect in acceptance order on a plain word array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat_off, output logic wr, output logic [31:0] wdat);
    int idx, sz, sh, width;
    logic [31:0] word, mask, v;
    idx = int'(a[9:2]);
    sz  = int'(f3[1:0]);
    word = ref_mem[idx];
    rd = 32'h0; wr = 1'b0; wdat = 32'h0; lat_off = 0;
    err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
          (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    if (err) return;
    if (!we) begin
      if (sz == 0) begin
        sh = int'(a[1:0]) * 8;
        v = (word >> sh) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        rd = v;
      end else if (sz == 1) begin
        sh = int'(a[1]) * 16;
        v = (word >> sh) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        rd = v;
      end else begin
        rd = word;
      end
    end else if (sz == 2) begin
      ref_mem[idx] = wd;
      wr = 1'b1;
      wdat = wd;
    end else begin
      width = (sz == 0) ? 8 : 16;
      sh = (sz == 0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
      mask = ((32'd1 << width) - 32'd1) << sh;
      word = (word & ~mask) | ((wd << sh) & mask);
      ref_mem[idx] = word;
      wr = 1'b1;
      wdat = word;
      lat_off = 1;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int acc_cyc, output logic wr_seen);
    int n;
    logic err, wr;
    logic [31:0] rd, wdat;
    int lat_off;
    n = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    while (bus.req_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      acc_cyc = -1;
      wr_seen = 1'b0;
      return;
    end
    wr_seen = bus.mem_wr_en;
    model(we, f3, a, wd, err, rd, lat_off, wr, wdat);
    exp_q.push_back('{rdata: rd, err: err, cyc: cyc + 1 + lat_off});
    if (wr) wr_q.push_back('{addr: {a[31:2], 2'b00}, data: wdat});
    accepts++;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ld_f3   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] ld_addr [4] = '{32'h100, 32'h100, 32'h102, 32'h102};
  logic [31:0] ld_exp  [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8765, 32'h0000_8765};
  logic        er_we   [3] = '{1'b0, 1'b1, 1'b1};
  logic [2:0]  er_f3   [3] = '{3'b010, 3'b001, 3'b100};
  logic [31:0] er_addr [3] = '{32'h102, 32'h103, 32'h100};

  initial begin
    int acc, prev_acc, acc1, acc2, mism, sel, off;
    logic wr, wr1, wr2, we;
    logic [2:0] f3;
    logic [31:0] val, a;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n = 1'b0;

    for (int i = 0; i < 256; i++) begin
      val = $urandom;
      if (i == 64)  val = 32'h8765_43F1;
      if (i == 128) val = 32'hCAFE_F00D;
      ref_mem[i] = val;
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 8'(i); pre_data = val;
    end
    @(negedge clk);
    pre_we = 1'b0;
    bus.req_addr = 32'h10F;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("idle_mem_addr", bus.mem_addr, 32'h10C);

    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ld_f3[i], ld_addr[i], 32'h0, acc, wr);
      chk("load_valid", 32'(bus.resp_valid), 32'd1);
      chk("load_rdata", bus.resp_rdata, ld_exp[i]);
      if (i > 0) chk("load_b2b_accept", acc, prev_acc + 1);
      prev_acc = acc;
    end

    issue(1'b1, 3'b000, 32'h101, 32'h1234_56AA, acc, wr);
    chk("sb_no_write_at_accept", 32'(wr), 32'd0);
    chk("sb_write_ready", 32'(bus.req_ready), 32'd0);
    chk("sb_write_en", 32'(bus.mem_wr_en), 32'd1);
    chk("sb_write_addr", bus.mem_addr, 32'h100);
    chk("sb_write_data", bus.mem_wdata, 32'h8765_AAF1);
    chk("sb_resp_early", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("sb_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("sb_ready_back", 32'(bus.req_ready), 32'd1);
    chk("sb_single_pulse", 32'(bus.mem_wr_en), 32'd0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc, wr);
    chk("sb_readback", bus.resp_rdata, 32'h8765_AAF1);

    issue(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, acc1, wr1);
    issue(1'b0, 3'b010, 32'h104, 32'h0, acc2, wr2);
    chk("sw_write_at_accept", 32'(wr1), 32'd1);
    chk("sw_lw_b2b_accept", acc2, acc1 + 1);
    chk("sw_lw_rdata", bus.resp_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 3; i++) begin
      issue(er_we[i], er_f3[i], er_addr[i], 32'hFFFF_FFFF, acc, wr);
      chk("err_no_write", 32'(wr), 32'd0);
      chk("err_valid", 32'(bus.resp_valid), 32'd1);
      chk("err_flag", 32'(bus.resp_err), 32'd1);
      chk("err_rdata", bus.resp_rdata, 32'h0);
    end

    repeat (2) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'h0000_5555;
    #1;
    chk("rstw_accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_wr_en_forced", 32'(bus.mem_wr_en), 32'd0);
    chk("rstw_ready_forced", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstw_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rstw_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rstw_mem_unchanged", tb_mem[128], 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_idle_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 3'b010, 32'h200, 32'h0, acc, wr);
    chk("rstw_readback", bus.resp_rdata, 32'hCAFE_F00D);

    for (int i = 0; i < 1000; i++) begin
      we = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 85) begin
        if (f3[1:0] == 2'b01) off = off & 2;
        if (f3[1:0] == 2'b10) off = 0;
      end
      a = {22'h0, 8'($urandom_range(0, 255)), 2'(off)};
      issue(we, f3, a, $urandom, acc, wr);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("one_resp_per_accept", resp_cnt, accepts);
    mism = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    chk("final_memory_mismatches", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
